// File: rtl/rr_stage.sv
// Register-read stage: 32xXLEN integer register file with WB write-before-read forwarding,
// plus the RR->EXE pipeline register with operand refresh while EXE is stalled.
module rr_stage #(
  parameter int INSTR_W = 96,
  parameter int XLEN    = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               kill_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [4:0]         rs1_i,
  input  logic [4:0]         rs2_i,
  input  logic [4:0]         rd_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               wb_valid_i,
  input  logic [4:0]         wb_rd_i,
  input  logic [XLEN-1:0]    wb_data_i,
  input  logic               exe_stall_i,
  output logic               exe_valid_o,
  output logic [4:0]         exe_rs1_o,
  output logic [4:0]         exe_rs2_o,
  output logic [4:0]         exe_rd_o,
  output logic [XLEN-1:0]    exe_data_rs1_o,
  output logic [XLEN-1:0]    exe_data_rs2_o,
  output logic [INSTR_W-1:0] exe_instr_o
);

  logic [XLEN-1:0] regs_q [32];
  logic            wb_en;
  logic            accept;
  logic [XLEN-1:0] rd_data_rs1;
  logic [XLEN-1:0] rd_data_rs2;

  assign wb_en   = wb_valid_i && (wb_rd_i != 5'd0);
  assign ready_o = ~exe_stall_i;
  assign accept  = valid_i && ready_o;

  // NOTE: the register file is reset because reset must clear architectural state;
  // this forces flops rather than a RAM macro. x0 is never written so it stays zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[wb_rd_i] <= wb_data_i;
    end
  end

  // Write-before-read: a WB write landing this cycle is visible to the reading instruction.
  always_comb begin
    rd_data_rs1 = regs_q[rs1_i];
    if (rs1_i == 5'd0)             rd_data_rs1 = '0;
    else if (wb_en && wb_rd_i == rs1_i) rd_data_rs1 = wb_data_i;
  end

  always_comb begin
    rd_data_rs2 = regs_q[rs2_i];
    if (rs2_i == 5'd0)             rd_data_rs2 = '0;
    else if (wb_en && wb_rd_i == rs2_i) rd_data_rs2 = wb_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exe_valid_o    <= 1'b0;
      exe_rs1_o      <= '0;
      exe_rs2_o      <= '0;
      exe_rd_o       <= '0;
      exe_data_rs1_o <= '0;
      exe_data_rs2_o <= '0;
      exe_instr_o    <= '0;
    end else if (kill_i) begin
      exe_valid_o <= 1'b0;
    end else if (!exe_stall_i) begin
      exe_valid_o <= valid_i;
      if (accept) begin
        exe_rs1_o      <= rs1_i;
        exe_rs2_o      <= rs2_i;
        exe_rd_o       <= rd_i;
        exe_data_rs1_o <= rd_data_rs1;
        exe_data_rs2_o <= rd_data_rs2;
        exe_instr_o    <= instr_i;
      end
    end else if (exe_valid_o) begin
      // Held instruction picks up results that retire while it waits in EXE.
      if (wb_en && wb_rd_i == exe_rs1_o) exe_data_rs1_o <= wb_data_i;
      if (wb_en && wb_rd_i == exe_rs2_o) exe_data_rs2_o <= wb_data_i;
    end
  end

endmodule

// File: tb/tb_rr_stage.sv
// Scoreboard bench for rr_stage: stimulus pushes expected EXE contents, a negedge
// monitor pops and compares whenever EXE consumes a valid instruction.
module tb_rr_stage;

  localparam int INSTR_W = 96;
  localparam int XLEN    = 64;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               kill_i, valid_i, ready_o;
  logic [4:0]         rs1_i, rs2_i, rd_i;
  logic [INSTR_W-1:0] instr_i;
  logic               wb_valid_i;
  logic [4:0]         wb_rd_i;
  logic [XLEN-1:0]    wb_data_i;
  logic               exe_stall_i;
  logic               exe_valid_o;
  logic [4:0]         exe_rs1_o, exe_rs2_o, exe_rd_o;
  logic [XLEN-1:0]    exe_data_rs1_o, exe_data_rs2_o;
  logic [INSTR_W-1:0] exe_instr_o;

  typedef struct {
    logic [4:0]         rs1, rs2, rd;
    logic [XLEN-1:0]    d1, d2;
    logic [INSTR_W-1:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  rr_stage #(.INSTR_W(INSTR_W), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .kill_i(kill_i), .valid_i(valid_i), .ready_o(ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .instr_i(instr_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .exe_stall_i(exe_stall_i), .exe_valid_o(exe_valid_o),
    .exe_rs1_o(exe_rs1_o), .exe_rs2_o(exe_rs2_o), .exe_rd_o(exe_rd_o),
    .exe_data_rs1_o(exe_data_rs1_o), .exe_data_rs2_o(exe_data_rs2_o),
    .exe_instr_o(exe_instr_o)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    valid_i = 1'b0; kill_i = 1'b0; exe_stall_i = 1'b0; wb_valid_i = 1'b0;
    rs1_i = '0; rs2_i = '0; rd_i = '0; instr_i = '0; wb_rd_i = '0; wb_data_i = '0;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [INSTR_W-1:0] instr);
    valid_i = 1'b1; rs1_i = rs1; rs2_i = rs2; rd_i = rd; instr_i = instr;
  endtask

  task automatic accept(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [INSTR_W-1:0] instr,
                        input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2);
    exp_t e;
    drive(rs1, rs2, rd, instr);
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.d1 = d1; e.d2 = d2; e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic wb(input logic [4:0] rd, input logic [XLEN-1:0] data);
    wb_valid_i = 1'b1; wb_rd_i = rd; wb_data_i = data;
  endtask

  // Monitor: an instruction leaves RR when EXE takes it; a kill drops it.
  always @(negedge clk_i) begin
    if (!rst_i && exe_valid_o) begin
      if (kill_i) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (!exe_stall_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_exe_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("exe_rs1", exe_rs1_o, e.rs1);
          check("exe_rs2", exe_rs2_o, e.rs2);
          check("exe_rd", exe_rd_o, e.rd);
          check("exe_data_rs1", exe_data_rs1_o, e.d1);
          check("exe_data_rs2", exe_data_rs2_o, e.d2);
          check("exe_instr", exe_instr_o, e.instr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    rst_i = 1'b1;
    #1;
    check("rst_valid", exe_valid_o, 0);
    check("rst_data_rs1", exe_data_rs1_o, 0);
    check("rst_data_rs2", exe_data_rs2_o, 0);
    check("rst_instr", exe_instr_o, 0);
    check("rst_rd", exe_rd_o, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    check("ready_no_stall", ready_o, 1);

    // T1: every register reads zero after reset
    for (int r = 1; r < 32; r++) begin
      accept(5'(r), 5'((r % 31) + 1), 5'(r), INSTR_W'(r), 64'h0, 64'h0);
      tick();
    end
    idle();
    tick();
    check("t1_idle_valid", exe_valid_o, 0);

    // T2: same-cycle WB forwarding, then regfile read of the committed value
    wb(5'd5, 64'hDEAD_BEEF);
    accept(5'd5, 5'd0, 5'd6, 96'h2, 64'hDEAD_BEEF, 64'h0);
    tick();
    idle();
    accept(5'd5, 5'd5, 5'd6, 96'h3, 64'hDEAD_BEEF, 64'hDEAD_BEEF);
    tick();

    // T3: x0 write ignored, x0 reads zero both with and without a concurrent x0 write
    idle();
    wb(5'd0, 64'hFFFF);
    accept(5'd0, 5'd0, 5'd1, 96'h30, 64'h0, 64'h0);
    tick();
    idle();
    accept(5'd0, 5'd5, 5'd1, 96'h31, 64'h0, 64'hDEAD_BEEF);
    tick();

    // T4: stall with operand refresh; ready low and payload held throughout
    idle();
    wb(5'd7, 64'h1);
    tick();
    idle();
    accept(5'd7, 5'd7, 5'd8, 96'h4, 64'd42, 64'd42);
    tick();
    idle();
    exe_stall_i = 1'b1;
    drive(5'd1, 5'd2, 5'd9, 96'hBAD);
    #1 check("t4_ready_c1", ready_o, 0);
    tick();
    wb(5'd7, 64'd42);
    #1 check("t4_ready_c2", ready_o, 0);
    tick();
    wb_valid_i = 1'b0;
    #1 check("t4_ready_c3", ready_o, 0);
    check("t4_instr_held", exe_instr_o, 96'h4);
    check("t4_refreshed_rs1", exe_data_rs1_o, 64'd42);
    tick();
    idle();
    tick();
    check("t4_drained", exe_valid_o, 0);

    // T5: kill beats stall; concurrent WB still commits; kill beats valid_i
    accept(5'd3, 5'd0, 5'd3, 96'h5, 64'h0, 64'h0);
    tick();
    idle();
    exe_stall_i = 1'b1;
    kill_i = 1'b1;
    wb(5'd3, 64'd9);
    tick();
    check("t5_kill_stall", exe_valid_o, 0);
    idle();
    kill_i = 1'b1;
    drive(5'd3, 5'd0, 5'd4, 96'h55);
    tick();
    check("t5_kill_valid", exe_valid_o, 0);
    idle();

    // T6: back-to-back dependent chain, each result forwarded from WB
    accept(5'd3, 5'd0, 5'd10, 96'h10, 64'd9, 64'h0);
    tick();
    check("t6_valid_1", exe_valid_o, 1);
    idle();
    wb(5'd10, 64'h100);
    accept(5'd10, 5'd0, 5'd11, 96'h11, 64'h100, 64'h0);
    tick();
    check("t6_valid_2", exe_valid_o, 1);
    idle();
    wb(5'd11, 64'h200);
    accept(5'd11, 5'd0, 5'd12, 96'h12, 64'h200, 64'h0);
    tick();
    check("t6_valid_3", exe_valid_o, 1);
    idle();
    wb(5'd12, 64'h300);
    accept(5'd12, 5'd0, 5'd13, 96'h13, 64'h300, 64'h0);
    tick();
    check("t6_valid_4", exe_valid_o, 1);
    idle();
    tick();
    check("t6_end_valid", exe_valid_o, 0);

    // Reset during a stall drops the held instruction and clears the regfile
    drive(5'd3, 5'd12, 5'd14, 96'h77);
    tick();
    idle();
    exe_stall_i = 1'b1;
    tick();
    rst_i = 1'b1;
    #1 check("rst_mid_stall_valid", exe_valid_o, 0);
    #1 rst_i = 1'b0;
    idle();
    accept(5'd3, 5'd12, 5'd14, 96'h78, 64'h0, 64'h0);
    tick();
    idle();
    repeat (2) tick();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
